// File: rtl/space_dash_pkg.sv
// rtl/space_dash_pkg.sv - shared types and screen constants for the space-dash game
package space_dash_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int AST_W    = 30;
  localparam int AST_H    = 20;

  typedef enum logic [1:0] {SCH_IDLE, SCH_RUN, SCH_FROZEN} sched_state_t;

  // Fold an out-of-range LFSR value back into 0..xmax instead of clamping, so edges stay rare.
  function automatic logic [9:0] clip_x(input logic [9:0] r, input logic [9:0] xmax);
    return (r > xmax) ? r - (xmax + 10'd1) : r;
  endfunction
endpackage

// File: rtl/lowest_free_slot.sv
// rtl/lowest_free_slot.sv - priority encoder picking the lowest set bit of a free-slot mask
module lowest_free_slot #(
  parameter int NSLOTS = 7
) (
  input  logic [NSLOTS-1:0]         free_mask,
  output logic [$clog2(NSLOTS)-1:0] idx,
  output logic                      any_free
);
  localparam int IW = $clog2(NSLOTS);

  always_comb begin
    idx      = '0;
    any_free = |free_mask;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/asteroid_scheduler.sv
// rtl/asteroid_scheduler.sv - asteroid slot pool, spawn timer and level/speed ramp
module asteroid_scheduler
  import space_dash_pkg::*;
#(
  parameter int NSLOTS       = 7,
  parameter int SPAWN_INIT   = 256,
  parameter int SPAWN_MIN    = 32,
  parameter int SPAWN_STEP   = 16,
  parameter int LEVEL_FRAMES = 2048,
  parameter int SPEED_MAX    = 4,
  parameter int XMAX         = SCREEN_W - AST_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic                      game_over,
  input  logic [9:0]                rng,
  input  logic [NSLOTS-1:0]         slot_done,
  output logic [NSLOTS-1:0]         slot_en,
  output logic                      spawn_valid,
  output logic [$clog2(NSLOTS)-1:0] spawn_slot,
  output logic [9:0]                spawn_x,
  output logic [2:0]                speed,
  output logic [3:0]                level
);
  localparam int FW = $clog2(LEVEL_FRAMES);

  sched_state_t              state;
  logic [10:0]               spawn_cnt;
  logic [FW-1:0]             frame_cnt;
  logic [10:0]               dec;
  logic [10:0]               period;
  logic [4:0]                lvl_plus1;
  logic [$clog2(NSLOTS)-1:0] free_idx;
  logic                      any_free;
  logic [NSLOTS-1:0]         alloc_mask;

  lowest_free_slot #(.NSLOTS(NSLOTS)) u_free (
    .free_mask(~slot_en),
    .idx      (free_idx),
    .any_free (any_free)
  );

  always_comb begin
    dec       = 11'(level) * 11'(SPAWN_STEP);
    if (dec >= 11'(SPAWN_INIT) || (11'(SPAWN_INIT) - dec) < 11'(SPAWN_MIN))
      period = 11'(SPAWN_MIN);
    else
      period = 11'(SPAWN_INIT) - dec;
    lvl_plus1 = {1'b0, level} + 5'd1;
    speed     = (lvl_plus1 > 5'(SPEED_MAX)) ? 3'(SPEED_MAX) : lvl_plus1[2:0];
    alloc_mask           = '0;
    alloc_mask[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCH_IDLE;
      slot_en     <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
      level       <= '0;
      spawn_cnt   <= '0;
      frame_cnt   <= '0;
    end else begin
      spawn_valid <= 1'b0;
      case (state)
        SCH_IDLE: begin
          if (start) begin
            state     <= SCH_RUN;
            spawn_cnt <= 11'(SPAWN_INIT);
            frame_cnt <= '0;
          end
        end
        SCH_RUN: begin
          if (game_over) begin
            state <= SCH_FROZEN;
          end else if (!start) begin
            state      <= SCH_IDLE;
            slot_en    <= '0;
            spawn_slot <= '0;
            spawn_x    <= '0;
            level      <= '0;
            spawn_cnt  <= '0;
            frame_cnt  <= '0;
          end else begin
            // Allocation looks at registered slot_en, so a slot freed this cycle waits one cycle.
            if (spawn_cnt == '0 && any_free) begin
              slot_en     <= (slot_en & ~slot_done) | alloc_mask;
              spawn_valid <= 1'b1;
              spawn_slot  <= free_idx;
              spawn_x     <= clip_x(rng, 10'(XMAX));
              spawn_cnt   <= period;
            end else begin
              slot_en <= slot_en & ~slot_done;
              if (frame_tick && spawn_cnt != '0) spawn_cnt <= spawn_cnt - 11'd1;
            end
            if (frame_tick) begin
              if (frame_cnt == FW'(LEVEL_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (level != 4'd15) level <= level + 4'd1;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
        end
        SCH_FROZEN: ;
        default: state <= SCH_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_asteroid_scheduler.sv
// tb/tb_asteroid_scheduler.sv - self-checking bench for asteroid_scheduler
module tb_asteroid_scheduler;
  localparam int NS = 7, SI = 64, SM = 32, SS = 16, LF = 8, SPM = 4, XM = 610;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, game_over;
  logic [9:0] rng;
  logic [6:0] slot_done, slot_en;
  logic       spawn_valid;
  logic [2:0] spawn_slot, speed;
  logic [9:0] spawn_x;
  logic [3:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  asteroid_scheduler #(
    .NSLOTS(NS), .SPAWN_INIT(SI), .SPAWN_MIN(SM), .SPAWN_STEP(SS),
    .LEVEL_FRAMES(LF), .SPEED_MAX(SPM), .XMAX(XM)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .game_over(game_over), .rng(rng), .slot_done(slot_done), .slot_en(slot_en),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_x(spawn_x),
    .speed(speed), .level(level)
  );

  // Reference model: mode 0 idle, 1 running, 2 frozen
  int     m_mode, m_cnt, m_fcnt, m_level, m_slot, m_x;
  bit [6:0] m_occ;
  bit     m_sv;

  function automatic int period_of(input int l);
    int p;
    p = SI - l * SS;
    return (p < SM) ? SM : p;
  endfunction

  function automatic void model_clear();
    m_mode = 0; m_cnt = 0; m_fcnt = 0; m_level = 0; m_slot = 0; m_x = 0;
    m_occ = '0; m_sv = 1'b0;
  endfunction

  function automatic void model_step();
    int k;
    bit [6:0] nocc;
    if (reset) begin
      model_clear();
      return;
    end
    m_sv = 1'b0;
    if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_cnt = SI; m_fcnt = 0; end
    end else if (m_mode == 1) begin
      if (game_over) m_mode = 2;
      else if (!start) model_clear();
      else begin
        nocc = m_occ & ~slot_done;
        k = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) k = i;
        if (m_cnt == 0 && k >= 0) begin
          nocc[k] = 1'b1; m_sv = 1'b1; m_slot = k;
          m_x = (int'(rng) > XM) ? int'(rng) - (XM + 1) : int'(rng);
          m_cnt = period_of(m_level);
        end else if (frame_tick && m_cnt > 0) m_cnt--;
        if (frame_tick) begin
          if (m_fcnt == LF - 1) begin m_fcnt = 0; if (m_level < 15) m_level++; end
          else m_fcnt++;
        end
        m_occ = nocc;
      end
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk); #1;
    chk("slot_en", 32'(slot_en), 32'(m_occ));
    chk("spawn_valid", 32'(spawn_valid), 32'(m_sv));
    chk("spawn_slot", 32'(spawn_slot), m_slot);
    chk("spawn_x", 32'(spawn_x), m_x);
    chk("level", 32'(level), m_level);
    chk("speed", 32'(speed), (m_level + 1 > SPM) ? SPM : m_level + 1);
  endtask

  task automatic wait_spawn(input int budget, input string name);
    int n = 0;
    do begin step(); n++; end while (!spawn_valid && n < budget);
    tests++;
    if (spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: no spawn_valid within %0d cycles", name, budget);
    end
  endtask

  typedef struct { int ticks; int lvl; int spd; } lvl_vec_t;
  typedef struct { logic [9:0] r; logic [9:0] x; } clip_vec_t;
  lvl_vec_t  lvl_tab[4];
  clip_vec_t clip_tab[6];

  initial begin
    int n;
    bit seen;
    lvl_tab[0] = '{8, 1, 2};    lvl_tab[1] = '{24, 3, 4};
    lvl_tab[2] = '{128, 15, 4}; lvl_tab[3] = '{200, 15, 4};
    clip_tab[0] = '{10'd100, 10'd100}; clip_tab[1] = '{10'd700, 10'd89};
    clip_tab[2] = '{10'd1023, 10'd412}; clip_tab[3] = '{10'd610, 10'd610};
    clip_tab[4] = '{10'd611, 10'd0};    clip_tab[5] = '{10'd0, 10'd0};

    reset = 1; start = 0; game_over = 0; frame_tick = 0; slot_done = 0; rng = 0;
    model_clear();
    step(); step();
    chk("rst_slot_en", 32'(slot_en), 0);
    chk("rst_valid", 32'(spawn_valid), 0);
    chk("rst_speed", 32'(speed), 1);
    chk("rst_level", 32'(level), 0);

    // First spawns: slot 0 with rng 100, then slot 1 with rng 700
    reset = 0; start = 1; step();
    rng = 100; frame_tick = 1;
    wait_spawn(200, "t2_first");
    chk("t2_slot", 32'(spawn_slot), 0);
    chk("t2_x", 32'(spawn_x), 100);
    chk("t2_en", 32'(slot_en), 7'b0000001);
    step();
    chk("t2_pulse_len", 32'(spawn_valid), 0);
    rng = 700;
    wait_spawn(200, "t2_second");
    chk("t2b_slot", 32'(spawn_slot), 1);
    chk("t2b_x", 32'(spawn_x), 89);
    chk("t2b_en", 32'(slot_en), 7'b0000011);

    // Fill the pool, then starve the timer
    n = 0;
    while (slot_en !== 7'h7f && n < 3000) begin step(); n++; end
    chk("t3_full", 32'(slot_en), 7'h7f);
    seen = 0;
    repeat (100) begin step(); if (spawn_valid) seen = 1; end
    chk("t3_no_spawn", 32'(seen), 0);
    frame_tick = 0; slot_done = 7'b0001000; step(); slot_done = 0;
    chk("t3_freed", 32'(slot_en), 7'b1110111);
    chk("t3_not_yet", 32'(spawn_valid), 0);
    step();
    chk("t3_respawn", 32'(spawn_valid), 1);
    chk("t3_slot", 32'(spawn_slot), 3);
    chk("t3_en", 32'(slot_en), 7'h7f);

    // Same-cycle release of slot 0 and spawn into slot 2
    slot_done = 7'b0000100; step(); slot_done = 0;
    chk("t6_free2", 32'(slot_en), 7'b1111011);
    frame_tick = 1; n = 0;
    while (m_cnt != 0 && n < 200) begin step(); n++; end
    frame_tick = 0; slot_done = 7'b0000001; step();
    chk("t6_both_en", 32'(slot_en), 7'b1111110);
    chk("t6_both_slot", 32'(spawn_slot), 2);
    chk("t6_both_valid", 32'(spawn_valid), 1);
    step();
    chk("t6_empty_done", 32'(slot_en), 7'b1111110);
    slot_done = 0; start = 0; step();
    chk("t6_idle_en", 32'(slot_en), 0);
    chk("t6_idle_level", 32'(level), 0);
    step();

    // Freeze with a partial pool
    start = 1; step(); frame_tick = 1;
    repeat (3) wait_spawn(200, "t5_fill");
    frame_tick = 0; slot_done = 7'b0000001; step(); slot_done = 0;
    game_over = 1; step();
    seen = 0;
    repeat (1000) begin
      frame_tick = 1'($urandom); start = 1'($urandom); game_over = 1'($urandom);
      slot_done = 7'h7f; rng = 10'($urandom);
      step();
      if (spawn_valid) seen = 1;
    end
    chk("t5_frozen_en", 32'(slot_en), 7'b0000110);
    chk("t5_no_spawn", 32'(seen), 0);
    slot_done = 0; game_over = 0; start = 0; frame_tick = 0;
    reset = 1; step(); reset = 0; step();
    chk("t5_rst_en", 32'(slot_en), 0);
    chk("t5_rst_speed", 32'(speed), 1);

    // Level/speed ramp table
    start = 1; step(); frame_tick = 1; n = 0;
    for (int v = 0; v < 4; v++) begin
      while (n < lvl_tab[v].ticks) begin step(); n++; end
      chk("t4_level", 32'(level), lvl_tab[v].lvl);
      chk("t4_speed", 32'(speed), lvl_tab[v].spd);
    end

    // Clip table: keep the pool draining so slot 0 is always free
    slot_done = 7'h7f;
    for (int v = 0; v < 6; v++) begin
      rng = clip_tab[v].r;
      wait_spawn(200, "clip_spawn");
      chk("clip_x", 32'(spawn_x), 32'(clip_tab[v].x));
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      start      = ($urandom_range(0, 99) != 0);
      game_over  = ($urandom_range(0, 799) == 0);
      frame_tick = 1'($urandom);
      rng        = 10'($urandom);
      slot_done  = 7'($urandom) & 7'($urandom) & 7'($urandom);
      step();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
